// File: rtl/sector_serializer.sv
// Serializes one sector frame (preamble, sync, WORDS memory words, optional checksum) per sector_strobe fall.
// Optional checksum trailer is enabled by defining SECTOR_CHECKSUM_EN.
module sector_serializer #(
   parameter int PREAMBLE_BITS = 200,
   parameter int WORDS         = 208
) (
   input  logic        clk25,
   input  logic        reset,
   input  logic        sector_strobe,
   input  logic [4:0]  sector,
   output logic        mem_rd,
   output logic [11:0] mem_addr,
   input  logic [15:0] mem_data,
   output logic        rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_SYNC, S_DATA, S_CHECK, S_POST
   } state_t;

   localparam logic [9:0] PRE_LAST = 10'(PREAMBLE_BITS - 1);
   localparam logic [7:0] LAST_IDX = 8'(WORDS - 1);

   state_t      state, state_n;
   logic        strobe_q;
   logic [3:0]  sec_q, sec_n;
   logic [9:0]  pre_cnt, pre_cnt_n;
   logic [3:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  word_idx, word_idx_n;
   logic [15:0] sr, sr_n;
`ifdef SECTOR_CHECKSUM_EN
   logic [15:0] csum, csum_n;
`endif

   logic        fall, rise, active, abort, last_word;
   logic        mem_rd_d, rd_data_d, rd_valid_d, overrun_d;
   logic [7:0]  rd_idx_d;
   logic        unused_sector_msb;

   assign unused_sector_msb = sector[4];
   assign fall      = !sector_strobe && strobe_q;
   assign rise      = sector_strobe && !strobe_q;
   assign active    = (state == S_PREAMBLE) || (state == S_SYNC) ||
                      (state == S_DATA) || (state == S_CHECK);
   assign abort     = active && rise;
   assign last_word = (word_idx == LAST_IDX);

   always_ff @(posedge clk25) begin
      if (reset) begin
         state    <= S_IDLE;
         strobe_q <= 1'b0;
      end else begin
         state    <= state_n;
         strobe_q <= sector_strobe;
      end
   end

   always_comb begin
      state_n    = state;
      sec_n      = sec_q;
      pre_cnt_n  = pre_cnt;
      bit_cnt_n  = bit_cnt;
      word_idx_n = word_idx;
      sr_n       = sr;
`ifdef SECTOR_CHECKSUM_EN
      csum_n     = csum;
`endif
      case (state)
         S_IDLE, S_POST: begin
            if (fall) begin
               state_n    = S_PREAMBLE;
               sec_n      = sector[3:0];
               pre_cnt_n  = '0;
               bit_cnt_n  = '0;
               word_idx_n = '0;
`ifdef SECTOR_CHECKSUM_EN
               csum_n     = '0;
`endif
            end
         end
         S_PREAMBLE: begin
            pre_cnt_n = pre_cnt + 10'd1;
            if (pre_cnt == PRE_LAST) state_n = S_SYNC;
         end
         S_SYNC: begin
            sr_n    = mem_data;
`ifdef SECTOR_CHECKSUM_EN
            csum_n  = csum ^ mem_data;
`endif
            state_n = S_DATA;
         end
         S_DATA: begin
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
               if (last_word) begin
`ifdef SECTOR_CHECKSUM_EN
                  state_n = S_CHECK;
`else
                  state_n = S_POST;
`endif
               end else begin
                  // Word fetched at bit 14 is on mem_data now
                  sr_n       = mem_data;
`ifdef SECTOR_CHECKSUM_EN
                  csum_n     = csum ^ mem_data;
`endif
                  word_idx_n = word_idx + 8'd1;
               end
            end else begin
               sr_n = {sr[14:0], 1'b0};
            end
         end
`ifdef SECTOR_CHECKSUM_EN
         S_CHECK: begin
            bit_cnt_n = bit_cnt + 4'd1;
            csum_n    = {csum[14:0], 1'b0};
            if (bit_cnt == 4'd15) state_n = S_POST;
         end
`endif
         default: state_n = S_IDLE;
      endcase
      if (abort) state_n = S_IDLE;
   end

   // Outputs decode the upcoming state so the registered pins line up with it
   always_comb begin
      rd_valid_d = (state_n == S_PREAMBLE) || (state_n == S_SYNC) ||
                   (state_n == S_DATA) || (state_n == S_CHECK);
      overrun_d  = abort;
      rd_data_d  = 1'b0;
      case (state_n)
         S_SYNC:  rd_data_d = 1'b1;
         S_DATA:  rd_data_d = sr_n[15];
`ifdef SECTOR_CHECKSUM_EN
         S_CHECK: rd_data_d = csum_n[15];
`endif
         default: rd_data_d = 1'b0;
      endcase
      mem_rd_d = ((state_n == S_PREAMBLE) && (pre_cnt_n == PRE_LAST)) ||
                 ((state_n == S_DATA) && (bit_cnt_n == 4'd14) && (word_idx_n != LAST_IDX));
      rd_idx_d = (state_n == S_DATA) ? word_idx_n + 8'd1 : 8'd0;
   end

   always_ff @(posedge clk25) begin
      sec_q    <= sec_n;
      pre_cnt  <= pre_cnt_n;
      bit_cnt  <= bit_cnt_n;
      word_idx <= word_idx_n;
      sr       <= sr_n;
`ifdef SECTOR_CHECKSUM_EN
      csum     <= csum_n;
`endif
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         rd_data  <= 1'b0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         mem_rd   <= mem_rd_d;
         if (mem_rd_d) mem_addr <= {sec_n, rd_idx_d};
         rd_data  <= rd_data_d;
         rd_valid <= rd_valid_d;
         busy     <= rd_valid_d;
         overrun  <= overrun_d;
      end
   end

endmodule

// File: doc/sector_serializer.md
# sector_serializer

- Downstream neighbour of the sector counter: turns each sector window into the serial read stream the controller sees.
- On the falling edge of `sector_strobe`, emits a fixed sector frame: preamble zeros, one sync bit, `WORDS` 16-bit data words fetched from sector memory MSB-first, and an optional XOR checksum.
- Output rate is one bit per `clk25` cycle.

## Interface
- `PREAMBLE_BITS`, 200: zero bits sent before sync; range 1..1023.
- `WORDS`, 208: data words per sector; range 1..256; must satisfy `PREAMBLE_BITS+17+16*WORDS <= 3786`.
- `clk25` in 1: 2.5 MHz bit clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk25`.
- `sector_strobe` in 1: sector window strobe from the sector counter.
- `sector` in 5: current sector number; bits [3:0] used.
- `mem_rd` out 1: one-cycle read request.
- `mem_addr` out 12: `{sector_latched[3:0], word_idx[7:0]}`.
- `mem_data` in 16: read data, valid exactly one cycle after `mem_rd`.
- `rd_data` out 1: serial bit.
- `rd_valid` out 1: high while a frame bit is driven.
- `busy` out 1: high in any state other than IDLE/POST.
- `overrun` out 1: one-cycle pulse when a frame is aborted by a new strobe.

## Operation
- States: IDLE, PREAMBLE, SYNC, DATA, CHECK, POST.
- IDLE/POST → PREAMBLE on strobe fall, i.e. `sector_strobe`=0 and the registered previous value =1. At that edge:
  - latch `sector[3:0]`;
  - clear `bit_cnt`, `word_idx` and checksum.
- PREAMBLE: `rd_data`=0 for `PREAMBLE_BITS` cycles.
  - Last cycle issues `mem_rd` with `word_idx`=0.
  - Then → SYNC.
- SYNC: `rd_data`=1 for 1 cycle.
  - `mem_data` is captured into the shift register at the end of this cycle.
  - Checksum ^= `mem_data`.
  - Then → DATA.
- DATA: shift register MSB out each cycle; `bit_cnt` 0..15.
  - At `bit_cnt`=14, if `word_idx` < `WORDS`-1: issue `mem_rd` for `word_idx`+1.
  - At `bit_cnt`=15, load that word into the shift register and XOR it into the checksum. `word_idx` increments.
  - After bit 15 of word `WORDS`-1 → CHECK.
- CHECK: 16 checksum bits, MSB first, then → POST.
- POST: `rd_valid`=0, `rd_data`=0; wait for the next strobe fall.
- Strobe rise (`sector_strobe`=1 while previous =0) in PREAMBLE/SYNC/DATA/CHECK:
  - pulse `overrun` for 1 cycle;
  - → IDLE and drop `rd_valid` the next cycle;
  - no `mem_rd` is issued that cycle.
- `sector_strobe` held high through reset release: no frame starts until its first fall.
- Widths: `word_idx` 8 bits, `bit_cnt` 4 bits, PREAMBLE counter 10 bits, checksum 16 bits XOR. No wrap occurs within a legal frame.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `busy`=0, `overrun`=0, `mem_rd`=0, `mem_addr`=0; state IDLE.
- Reset mid-frame: aborts next cycle with the same values and no `overrun` pulse.
- Let t = the first cycle with `sector_strobe`=0 after a high cycle.
  - `rd_valid` rises at t+1 and stays high for exactly `PREAMBLE_BITS`+1+16·`WORDS`(+16) cycles.
  - With defaults and checksum enabled: 3545 cycles.
- Sync bit at cycle t+1+`PREAMBLE_BITS`.
- All outputs registered; `mem_rd` is a single-cycle pulse per word, `WORDS` pulses per frame.
- `mem_addr` is stable in the `mem_rd` cycle.

## Configuration
- `SECTOR_CHECKSUM_EN` defined:
  - CHECK state present; 16 checksum bits follow the data;
  - frame length `PREAMBLE_BITS`+17+16·`WORDS`.
- Undefined:
  - CHECK state and checksum register removed; DATA → POST directly;
  - frame length `PREAMBLE_BITS`+1+16·`WORDS`.

## Test plan
- Reset, then strobe high 120 cycles, low (defaults, checksum on):
  - `rd_valid` high 3545 cycles starting t+1;
  - first 200 bits 0, bit 201 =1;
  - 208 `mem_rd` pulses.
- Sector 5, memory word i = 16'hA500+i:
  - `mem_addr` 12'h500..12'h5CF;
  - serial words match MSB-first;
  - checksum equals XOR of all 208 words.
- `PREAMBLE_BITS`=4, `WORDS`=2, words 16'h8001/16'hFFFF:
  - stream 0000 1 1000000000000001 1111111111111111 0111111111111110.
- Strobe re-asserted at sync+50 cycles:
  - `overrun` pulses once;
  - `rd_valid` low next cycle;
  - next strobe fall starts a clean frame.
- Reset asserted mid-DATA:
  - all outputs 0 next cycle;
  - no `overrun`;
  - no frame until a strobe fall.
- Build without `SECTOR_CHECKSUM_EN`: defaults give `rd_valid` high exactly 3529 cycles.
